p23_mem_arbiter: RTL and testbench



---
 rtl/p23_mem_arbiter_pkg.sv | 19 +
 rtl/p23_mem_arbiter_rr_pick.sv | 28 ++
 rtl/p23_mem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_p23_mem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/p23_mem_arbiter_pkg.sv
// Shared definitions for the p23 memory-port arbiter.
//   arb_state_t : 2-bit arbiter state encoding (IDLE, GNT_CPU, GNT_AUX, LOCKED)
//   OWNER_CPU / OWNER_AUX : encoding of the owner/last-grant bit
//   IDLE_CNT_W  : width of the lock-idle counter (covers LOCK_TIMEOUT up to 255)
package p23_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GNT_CPU = 2'd1,
    ST_GNT_AUX = 2'd2,
    ST_LOCKED  = 2'd3
  } arb_state_t;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_AUX = 1'b1;

  localparam int IDLE_CNT_W = 8;

endpackage

// File: rtl/p23_mem_arbiter_rr_pick.sv
// p23_rr_pick: combinational two-way round-robin select.
// Ports:
//   cpu_valid, aux_valid : pending requests
//   last                 : owner of the most recent grant (OWNER_CPU/OWNER_AUX)
//   pick_valid           : at least one request is pending
//   pick_owner           : requester to grant; on conflict the one that did not win last
module p23_rr_pick
  import p23_mem_arbiter_pkg::*;
(
  input  logic cpu_valid,
  input  logic aux_valid,
  input  logic last,
  output logic pick_valid,
  output logic pick_owner
);

  always_comb begin
    pick_valid = cpu_valid | aux_valid;
    if (cpu_valid && aux_valid) begin
      pick_owner = ~last;
    end else if (aux_valid) begin
      pick_owner = OWNER_AUX;
    end else begin
      pick_owner = OWNER_CPU;
    end
  end

endmodule

// File: rtl/p23_mem_arbiter.sv
// p23_mem_arbiter: two-requester (CPU, AUX) arbiter in front of one memory port.
// Round-robin grant on conflict; optional CPU bus lock keeps the port across an
// AMO read-modify-write pair, bounded by a lock-idle timeout.
// Optional feature macro: P23_ARB_LOCK_EN (LOCKED state, idle counter, timeout).
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   cpu_* / aux_*              : requester ports (valid/ready, hold-until-ready)
//   cpu_lock                   : keep the port after the current CPU beat
//   mem_*                      : downstream port (valid/ready, same protocol)
//   owner                      : current or last grant (0 = CPU, 1 = AUX)
//   locked                     : high while the CPU holds the port with no beat in flight
module p23_mem_arbiter
  import p23_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int LOCK_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_valid,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [31:0]           cpu_wdata,
  input  logic [3:0]            cpu_wstrb,
  input  logic                  cpu_lock,
  output logic                  cpu_ready,
  output logic [31:0]           cpu_rdata,
  input  logic                  aux_valid,
  input  logic [ADDR_WIDTH-1:0] aux_addr,
  input  logic [31:0]           aux_wdata,
  input  logic [3:0]            aux_wstrb,
  output logic                  aux_ready,
  output logic [31:0]           aux_rdata,
  output logic                  mem_valid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_ready,
  input  logic [31:0]           mem_rdata,
  output logic                  owner,
  output logic                  locked
);

  arb_state_t state_q, state_d;
  logic       last_q, last_d;
  logic       owner_q, owner_d;
  logic       pick_valid;
  logic       pick_owner;

`ifdef P23_ARB_LOCK_EN
  // Last count value before expiry: the LOCK_TIMEOUT-th idle cycle releases the lock.
  localparam logic [IDLE_CNT_W-1:0] TIMEOUT_LAST = IDLE_CNT_W'(LOCK_TIMEOUT - 1);
  logic [IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
`else
  // Lock feature not built: keep the port and parameter without logic behind them.
  localparam int LOCK_TIMEOUT_UNUSED = LOCK_TIMEOUT;
  logic lock_unused;
  assign lock_unused = cpu_lock;
`endif

  p23_rr_pick u_rr_pick (
    .cpu_valid  (cpu_valid),
    .aux_valid  (aux_valid),
    .last       (last_q),
    .pick_valid (pick_valid),
    .pick_owner (pick_owner)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      last_q     <= OWNER_AUX;   // CPU wins the first conflict
      owner_q    <= OWNER_CPU;
`ifdef P23_ARB_LOCK_EN
      idle_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
`ifdef P23_ARB_LOCK_EN
      idle_cnt_q <= idle_cnt_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    owner_d    = owner_q;
`ifdef P23_ARB_LOCK_EN
    idle_cnt_d = idle_cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = (pick_owner == OWNER_AUX) ? ST_GNT_AUX : ST_GNT_CPU;
          last_d  = pick_owner;
          owner_d = pick_owner;
        end
      end
      ST_GNT_CPU: begin
        if (mem_ready) begin
`ifdef P23_ARB_LOCK_EN
          if (cpu_lock) begin
            state_d    = ST_LOCKED;
            idle_cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
`else
          state_d = ST_IDLE;
`endif
        end
      end
      ST_GNT_AUX: begin
        if (mem_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCKED: begin
`ifdef P23_ARB_LOCK_EN
        // A CPU request beats both an unlock and a timeout in the same cycle.
        if (cpu_valid) begin
          state_d = ST_GNT_CPU;
          last_d  = OWNER_CPU;
          owner_d = OWNER_CPU;
        end else if (!cpu_lock) begin
          state_d = ST_IDLE;
        end else if (idle_cnt_q == TIMEOUT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: downstream mux and ready routing follow the registered state.
  always_comb begin
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    cpu_ready = 1'b0;
    aux_ready = 1'b0;
    unique case (state_q)
      ST_GNT_CPU: begin
        mem_valid = 1'b1;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_wstrb = cpu_wstrb;
        cpu_ready = mem_ready;
      end
      ST_GNT_AUX: begin
        mem_valid = 1'b1;
        mem_addr  = aux_addr;
        mem_wdata = aux_wdata;
        mem_wstrb = aux_wstrb;
        aux_ready = mem_ready;
      end
      default: ;
    endcase
  end

  assign cpu_rdata = mem_rdata;
  assign aux_rdata = mem_rdata;
  assign owner     = owner_q;
`ifdef P23_ARB_LOCK_EN
  assign locked    = (state_q == ST_LOCKED);
`else
  assign locked    = 1'b0;
`endif

endmodule

// File: tb/tb_p23_mem_arbiter.sv
// Self-checking bench for p23_mem_arbiter: directed scenarios plus randomized
// traffic, checked cycle by cycle against a transaction-level reference model.
module tb_p23_mem_arbiter;

  localparam int AW = 32;
  localparam int TO = 15;
`ifdef P23_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_valid, cpu_lock, aux_valid, mem_ready;
  logic [AW-1:0] cpu_addr, aux_addr;
  logic [31:0]   cpu_wdata, aux_wdata, mem_rdata;
  logic [3:0]    cpu_wstrb, aux_wstrb;
  logic          cpu_ready, aux_ready, mem_valid, owner, locked;
  logic [31:0]   cpu_rdata, aux_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_wstrb;

  always #5 clk = ~clk;

  p23_mem_arbiter #(.ADDR_WIDTH(AW), .LOCK_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wstrb(cpu_wstrb), .cpu_lock(cpu_lock), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .aux_valid(aux_valid), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_wstrb(aux_wstrb), .aux_ready(aux_ready), .aux_rdata(aux_rdata),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .owner(owner), .locked(locked)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        lock;
  } req_t;

  req_t        cpu_q[$], aux_q[$];
  req_t        cpu_cur, aux_cur;
  bit          cpu_act, aux_act, cpu_lock_hold;
  bit          rnd_req, rnd_ready, rdata_fix_en;
  logic [31:0] rdata_fix;

  // Reference model: who is using the port (0 none, 1 CPU, 2 AUX), whether the
  // CPU is holding the port between beats, idle cycles spent holding, last winner.
  int m_busy, m_idle;
  bit m_hold, m_last, m_owner;
  bit e_cpu_rdy, e_aux_rdy;

  int cyc;
  int cpu_done[$], aux_done[$];
  int locked_cycles;

  // Requesters must hold valid until ready.
  bit cpu_wait, aux_wait;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_wait <= 1'b0;
      aux_wait <= 1'b0;
    end else begin
      if (cpu_wait) check_eq("proto_cpu_hold", cpu_valid, 1);
      if (aux_wait) check_eq("proto_aux_hold", aux_valid, 1);
      cpu_wait <= cpu_valid && !cpu_ready;
      aux_wait <= aux_valid && !aux_ready;
    end
  end

  function automatic req_t rand_req();
    req_t r;
    r.addr  = $urandom;
    r.wdata = $urandom;
    r.wstrb = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom);
    r.lock  = ($urandom_range(3) == 0);
    return r;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_hold = 0; m_idle = 0; m_last = 1'b1; m_owner = 1'b0;
  endtask

  // Called at a falling edge: asserts reset and releases it at the next falling edge.
  task automatic do_reset();
    reset = 1'b1;
    cpu_q.delete(); aux_q.delete();
    cpu_act = 0; aux_act = 0; cpu_lock_hold = 0;
    cpu_valid = 0; cpu_lock = 0; aux_valid = 0; mem_ready = 0;
    cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
    aux_addr = '0; aux_wdata = '0; aux_wstrb = '0; mem_rdata = '0;
    model_reset();
    @(negedge clk);
    check_eq("rst_mem_valid", mem_valid, 0);
    check_eq("rst_owner", owner, 0);
    check_eq("rst_locked", locked, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_readies", {cpu_ready, aux_ready}, 0);
    reset = 1'b0;
    cyc = 0;
    cpu_done.delete(); aux_done.delete();
    locked_cycles = 0;
  endtask

  task automatic drive();
    if (rnd_req) begin
      if (!cpu_act && cpu_q.size() == 0 && $urandom_range(2) == 0) cpu_q.push_back(rand_req());
      if (!aux_act && aux_q.size() == 0 && $urandom_range(2) == 0) aux_q.push_back(rand_req());
    end
    if (!cpu_act && cpu_q.size() > 0) begin cpu_cur = cpu_q.pop_front(); cpu_act = 1; end
    if (!aux_act && aux_q.size() > 0) begin aux_cur = aux_q.pop_front(); aux_act = 1; end
    cpu_valid = cpu_act;
    cpu_addr  = cpu_act ? cpu_cur.addr  : $urandom;
    cpu_wdata = cpu_act ? cpu_cur.wdata : $urandom;
    cpu_wstrb = cpu_act ? cpu_cur.wstrb : 4'($urandom);
    cpu_lock  = cpu_act ? cpu_cur.lock  : cpu_lock_hold;
    aux_valid = aux_act;
    aux_addr  = aux_act ? aux_cur.addr  : $urandom;
    aux_wdata = aux_act ? aux_cur.wdata : $urandom;
    aux_wstrb = aux_act ? aux_cur.wstrb : 4'($urandom);
    mem_ready = rnd_ready ? 1'($urandom_range(1)) : 1'b1;
    mem_rdata = rdata_fix_en ? rdata_fix : $urandom;
  endtask

  task automatic cycle_chk();
    logic [31:0] ea, ew;
    logic [3:0]  es;
    #1;
    e_cpu_rdy = (m_busy == 1) && mem_ready;
    e_aux_rdy = (m_busy == 2) && mem_ready;
    ea = (m_busy == 1) ? cpu_addr  : (m_busy == 2) ? aux_addr  : 32'h0;
    ew = (m_busy == 1) ? cpu_wdata : (m_busy == 2) ? aux_wdata : 32'h0;
    es = (m_busy == 1) ? cpu_wstrb : (m_busy == 2) ? aux_wstrb : 4'h0;
    check_eq("mem_valid", mem_valid, m_busy != 0);
    check_eq("mem_addr", mem_addr, ea);
    check_eq("mem_wdata", mem_wdata, ew);
    check_eq("mem_wstrb", mem_wstrb, es);
    check_eq("cpu_ready", cpu_ready, e_cpu_rdy);
    check_eq("aux_ready", aux_ready, e_aux_rdy);
    check_eq("cpu_rdata", cpu_rdata, mem_rdata);
    check_eq("aux_rdata", aux_rdata, mem_rdata);
    check_eq("owner", owner, m_owner);
    check_eq("locked", locked, m_hold);
    if (cpu_ready) cpu_done.push_back(cyc);
    if (aux_ready) aux_done.push_back(cyc);
    if (locked) locked_cycles++;
  endtask

  task automatic cycle_adv();
    int nb, ni;
    bit nh, nl, no, w;
    nb = m_busy; ni = m_idle; nh = m_hold; nl = m_last; no = m_owner;
    if (m_busy == 1) begin
      if (mem_ready) begin
        nb = 0;
        if (LOCK_EN && cpu_lock) begin nh = 1; ni = 0; end
      end
    end else if (m_busy == 2) begin
      if (mem_ready) nb = 0;
    end else if (m_hold) begin
      if (cpu_valid) begin
        nh = 0; nb = 1; nl = 1'b0; no = 1'b0;
      end else if (!cpu_lock) begin
        nh = 0;
      end else begin
        ni = m_idle + 1;
        if (ni >= TO) nh = 0;
      end
    end else if (cpu_valid || aux_valid) begin
      w  = (cpu_valid && aux_valid) ? !m_last : aux_valid;
      nb = w ? 2 : 1; nl = w; no = w;
    end
    @(posedge clk);
    m_busy = nb; m_idle = ni; m_hold = nh; m_last = nl; m_owner = no;
    if (e_cpu_rdy) begin cpu_act = 0; cpu_lock_hold = cpu_cur.lock; end
    if (e_aux_rdy) aux_act = 0;
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      drive();
      cycle_chk();
      cycle_adv();
    end
  endtask

  initial begin
    int n;
    rnd_req = 0; rnd_ready = 0; rdata_fix_en = 0; rdata_fix = '0;
    @(negedge clk);

    // Single CPU read from reset.
    do_reset();
    rdata_fix_en = 1; rdata_fix = 32'hDEADBEEF;
    cpu_q.push_back('{32'h100, 32'h0, 4'h0, 1'b0});
    run(1);
    drive();
    cycle_chk();
    check_eq("s1_mem_valid", mem_valid, 1);
    check_eq("s1_mem_addr", mem_addr, 32'h100);
    check_eq("s1_cpu_ready", cpu_ready, 1);
    check_eq("s1_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    check_eq("s1_owner", owner, 0);
    cycle_adv();
    run(2);
    rdata_fix_en = 0;

    // Simultaneous repeated requests alternate, one idle cycle between beats.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      cpu_q.push_back(rand_req()); cpu_q[i].lock = 0;
      aux_q.push_back(rand_req());
    end
    run(10);
    n = cpu_done.size();
    check_eq("s2_cpu_beats", n, 2);
    if (n >= 2) check_eq("s2_cpu_cycles", {cpu_done[0], cpu_done[1]}, {32'd1, 32'd5});
    n = aux_done.size();
    check_eq("s2_aux_beats", n, 2);
    if (n >= 2) check_eq("s2_aux_cycles", {aux_done[0], aux_done[1]}, {32'd3, 32'd7});

    // Locked read-modify-write pair with AUX pending.
    do_reset();
    cpu_q.push_back('{32'h200, 32'h0, 4'h0, 1'b1});
    cpu_q.push_back('{32'h200, 32'h5, 4'hF, 1'b0});
    aux_q.push_back('{32'h400, 32'h0, 4'h0, 1'b0});
    run(8);
    n = cpu_done.size();
    check_eq("s3_cpu_beats", n, 2);
    if (n >= 2) check_eq("s3_cpu_cycles", {cpu_done[0], cpu_done[1]},
                         LOCK_EN ? {32'd1, 32'd3} : {32'd1, 32'd5});
    n = aux_done.size();
    check_eq("s3_aux_beats", n, 1);
    if (n >= 1) check_eq("s3_aux_cycle", aux_done[0], LOCK_EN ? 5 : 3);
    check_eq("s3_locked_cycles", locked_cycles, LOCK_EN ? 1 : 0);

    // Lock held with no further CPU beat: forced release after the timeout.
    do_reset();
    cpu_q.push_back('{32'h300, 32'h0, 4'h0, 1'b1});
    aux_q.push_back('{32'h500, 32'h0, 4'h0, 1'b0});
    run(22);
    check_eq("s4_locked_cycles", locked_cycles, LOCK_EN ? TO : 0);
    n = aux_done.size();
    check_eq("s4_aux_beats", n, 1);
    if (n >= 1) check_eq("s4_aux_cycle", aux_done[0], LOCK_EN ? TO + 3 : 3);
    cpu_lock_hold = 0;

    // Reset in the middle of an AUX beat.
    do_reset();
    aux_q.push_back('{32'h600, 32'h0, 4'h0, 1'b0});
    run(1);
    drive();
    mem_ready = 1'b0;
    cycle_chk();
    check_eq("s5_pre_mem_valid", mem_valid, 1);
    check_eq("s5_pre_owner", owner, 1);
    #2;
    mem_ready = 1'b1;
    reset = 1'b1;
    #1;
    check_eq("s5_mem_valid", mem_valid, 0);
    check_eq("s5_aux_ready", aux_ready, 0);
    check_eq("s5_owner", owner, 0);
    @(negedge clk);
    do_reset();
    cpu_q.push_back('{32'h700, 32'h0, 4'h0, 1'b0});
    aux_q.push_back('{32'h800, 32'h0, 4'h0, 1'b0});
    run(3);
    n = cpu_done.size();
    check_eq("s5_first_cpu", n, 1);
    check_eq("s5_no_aux_yet", aux_done.size(), 0);

    // Randomized traffic with random downstream stalls.
    do_reset();
    rnd_req = 1; rnd_ready = 1;
    run(3000);
    rnd_req = 0; rnd_ready = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
